mem_write_checker: RTL



---
 rtl/mwchk_pkg.sv | 26 ++
 rtl/mwchk_match.sv | 60 ++++++
 rtl/mem_write_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mwchk_pkg.sv
// mwchk_pkg: shared types and helpers for the mem_write_checker slice.
//   mwchk_state_t : checker FSM states
//   mwchk_fail_t  : failure codes as reported on fail_code
//   mwchk_cnt_w() : bit width of a counter/index that spans 0..n-1 (never below 1)
package mwchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } mwchk_state_t;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_UNEXP   = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_DUP     = 2'd3
  } mwchk_fail_t;

  function automatic int unsigned mwchk_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mwchk_match.sv
// mwchk_match: combinational comparison of one store against the expected table.
// Ports:
//   i_addr/i_data           : store under evaluation
//   i_exp_addr/i_exp_data   : packed expected table, entry i at [i*W +: W]
//   i_seen                  : entries already matched
//   i_match_cnt             : number of matches so far (ordered-mode pointer)
//   o_hit                   : eligible entries equal to the store
//   o_dup                   : store equals an already-seen entry (unordered only)
//   o_hit_idx               : lowest index set in o_hit
module mwchk_match
  import mwchk_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_EXP   = 4,
  parameter bit          ORDERED = 1'b1,
  parameter int unsigned CNT_W   = $clog2(N_EXP + 1),
  parameter int unsigned IDX_W   = mwchk_cnt_w(N_EXP)
) (
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [N_EXP*ADDR_W-1:0] i_exp_addr,
  input  logic [N_EXP*DATA_W-1:0] i_exp_data,
  input  logic [N_EXP-1:0]        i_seen,
  input  logic [CNT_W-1:0]        i_match_cnt,
  output logic [N_EXP-1:0]        o_hit,
  output logic                    o_dup,
  output logic [IDX_W-1:0]        o_hit_idx
);

  logic [N_EXP-1:0] w_eq;
  logic [N_EXP-1:0] w_elig;
  logic             w_found;

  always_comb begin
    w_eq   = '0;
    w_elig = '0;
    for (int unsigned i = 0; i < N_EXP; i++) begin
      w_eq[i] = (i_addr == i_exp_addr[i*ADDR_W +: ADDR_W]) &&
                (i_data == i_exp_data[i*DATA_W +: DATA_W]);
      // Ordered mode: only the entry at the match pointer may be consumed.
      w_elig[i] = ORDERED ? (CNT_W'(i) == i_match_cnt) : !i_seen[i];
    end
  end

  assign o_hit = w_eq & w_elig;
  assign o_dup = !ORDERED && |(w_eq & i_seen);

  always_comb begin
    o_hit_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < N_EXP; i++) begin
      if (o_hit[i] && !w_found) begin
        o_hit_idx = IDX_W'(i);
        w_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: monitors the data-memory write port of the pipelined MIPS
// top and compares stores against N_EXP expected (addr, data) pairs, in table
// order (ORDERED=1) or any order. Stores to ign_addr are tolerated when
// ign_valid is set. A cycle timeout bounds the RUN phase. The verdict latches
// until reset.
// Ports:
//   clk, reset (async, active low), en (start / keep checking)
//   memwrite, dataadr, writedata : observed store port
//   exp_addr, exp_data           : packed expected table (stable from RUN entry)
//   ign_valid, ign_addr          : scratch-address tolerance
//   done, pass, fail_code        : verdict (0 none, 1 unexpected, 2 timeout, 3 duplicate)
//   match_cnt                    : expected stores matched so far
//   bad_addr, bad_data           : offending store
// Build option: define MWCHK_CAPTURE_EN to capture the offending store into
// bad_addr/bad_data; otherwise both read as zero.
module mem_write_checker
  import mwchk_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_EXP       = 4,
  parameter bit          ORDERED     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         memwrite,
  input  logic [ADDR_W-1:0]            dataadr,
  input  logic [DATA_W-1:0]            writedata,
  input  logic [N_EXP*ADDR_W-1:0]      exp_addr,
  input  logic [N_EXP*DATA_W-1:0]      exp_data,
  input  logic                         ign_valid,
  input  logic [ADDR_W-1:0]            ign_addr,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [$clog2(N_EXP+1)-1:0]   match_cnt,
  output logic [ADDR_W-1:0]            bad_addr,
  output logic [DATA_W-1:0]            bad_data
);

  localparam int unsigned CNT_W = $clog2(N_EXP + 1);
  localparam int unsigned TCW   = mwchk_cnt_w(TIMEOUT_CYC);
  localparam int unsigned IDX_W = mwchk_cnt_w(N_EXP);

  mwchk_state_t     r_state,     w_state_nx;
  mwchk_fail_t      r_fail,      w_fail_nx;
  logic [TCW-1:0]   r_cyc,       w_cyc_nx;
  logic [N_EXP-1:0] r_seen,      w_seen_nx;
  logic [CNT_W-1:0] r_match_cnt, w_cnt_nx;

  logic [N_EXP-1:0] w_hit;
  logic             w_dup;
  logic [IDX_W-1:0] w_hit_idx;
  logic [CNT_W-1:0] w_cnt_inc;

  mwchk_match #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_EXP  (N_EXP),
    .ORDERED(ORDERED),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .i_addr     (dataadr),
    .i_data     (writedata),
    .i_exp_addr (exp_addr),
    .i_exp_data (exp_data),
    .i_seen     (r_seen),
    .i_match_cnt(r_match_cnt),
    .o_hit      (w_hit),
    .o_dup      (w_dup),
    .o_hit_idx  (w_hit_idx)
  );

  assign w_cnt_inc = r_match_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fail      <= FAIL_NONE;
      r_cyc       <= '0;
      r_seen      <= '0;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_fail      <= w_fail_nx;
      r_cyc       <= w_cyc_nx;
      r_seen      <= w_seen_nx;
      r_match_cnt <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_fail_nx  = r_fail;
    w_cyc_nx   = r_cyc;
    w_seen_nx  = r_seen;
    w_cnt_nx   = r_match_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nx = ST_RUN;
          w_cyc_nx   = '0;
        end
      end
      ST_RUN: begin
        // en low freezes everything: counter, table state and store evaluation.
        if (en) begin
          w_cyc_nx = r_cyc + TCW'(1);
          if (memwrite && |w_hit) begin
            w_seen_nx = r_seen | (N_EXP'(1) << w_hit_idx);
            w_cnt_nx  = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(N_EXP)) w_state_nx = ST_PASS;
          end else if (memwrite && w_dup) begin
            w_state_nx = ST_FAIL;
            w_fail_nx  = FAIL_DUP;
          end else if (memwrite && !(ign_valid && dataadr == ign_addr)) begin
            w_state_nx = ST_FAIL;
            w_fail_nx  = FAIL_UNEXP;
          end
          // A store verdict in the last cycle wins over the timeout.
          if (w_state_nx == ST_RUN && r_cyc == TCW'(TIMEOUT_CYC - 1)) begin
            w_state_nx = ST_TIMEOUT;
            w_fail_nx  = FAIL_TIMEOUT;
          end
        end
      end
      default: ;
    endcase
  end

  assign done      = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
  assign pass      = (r_state == ST_PASS);
  assign fail_code = r_fail;
  assign match_cnt = r_match_cnt;

`ifdef MWCHK_CAPTURE_EN
  logic [ADDR_W-1:0] r_bad_addr;
  logic [DATA_W-1:0] r_bad_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bad_addr <= '0;
      r_bad_data <= '0;
    end else if (r_state == ST_RUN && w_state_nx == ST_FAIL) begin
      r_bad_addr <= dataadr;
      r_bad_data <= writedata;
    end
  end

  assign bad_addr = r_bad_addr;
  assign bad_data = r_bad_data;
`else
  assign bad_addr = '0;
  assign bad_data = '0;
`endif

endmodule
